dmem_responder: RTL and testbench

- Responder side of the processor's data-memory interface. Accepts one load/store request at a time from the memory-access stage over a valid/ready handshake.
- Services each request with a programmable fixed latency and returns read data plus an error flag through a one-cycle response strobe.
- Drives a stall signal that the pipeline uses to gate its stage clocks while a request waits.

---
 rtl/dmem_responder.sv | 148 ++++++++++++++
 tb/tb_dmem_responder.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_responder.sv
// Data-memory responder: one outstanding load/store, fixed LATENCY, one-cycle response strobe.
// Optional build macro DMEM_RESET_CLEAR_EN zero-fills the memory after every reset.
module dmem_responder #(
  parameter int DATA_WIDTH  = 16,
  parameter int ADDR_WIDTH  = 16,
  parameter int DEPTH_WORDS = 256,
  parameter int LATENCY     = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  rsp_valid,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  rsp_err,
  output logic                  stall,
  output logic [1:0]            o_dbg_state
);

  localparam int AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam logic [ADDR_WIDTH:0] DEPTH_L = (ADDR_WIDTH + 1)'(DEPTH_WORDS);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
`ifdef DMEM_RESET_CLEAR_EN
    , S_CLEAR = 2'd3
`endif
  } state_t;

  // Handshake: a request transfers at the posedge where req_valid and req_ready are both 1;
  // req_ready depends only on the state register, never on req_valid.
  state_t                r_state;
  logic [3:0]            r_cnt;
  logic                  r_we;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [DATA_WIDTH-1:0] r_wdata;
  logic [DATA_WIDTH-1:0] r_rdata;
  logic                  r_err;
  logic [DATA_WIDTH-1:0] r_mem [DEPTH_WORDS];
`ifdef DMEM_RESET_CLEAR_EN
  logic [AW-1:0]         r_clr_cnt;
`endif

  logic                  w_accept;
  logic                  w_commit;
  logic                  w_c_we;
  logic [ADDR_WIDTH-1:0] w_c_addr;
  logic [DATA_WIDTH-1:0] w_c_wdata;
  logic [ADDR_WIDTH-2:0] w_idx;
  logic [AW-1:0]         w_widx;
  logic                  w_err;
  logic                  w_mem_we;
  logic [AW-1:0]         w_mem_waddr;
  logic [DATA_WIDTH-1:0] w_mem_wdata;

  assign req_ready   = (r_state == S_IDLE) || (r_state == S_RESP);
  assign rsp_valid   = (r_state == S_RESP);
  assign rsp_rdata   = r_rdata;
  assign rsp_err     = r_err;
  assign stall       = req_valid & ~req_ready;
  assign o_dbg_state = r_state;
  assign w_accept    = req_valid & req_ready;

  // With LATENCY=1 the accept edge is also the commit edge, so the live inputs are used.
  always_comb begin
    w_commit  = (LATENCY == 1) ? w_accept : ((r_state == S_WAIT) && (r_cnt == 4'd0));
    w_c_we    = (LATENCY == 1) ? req_we    : r_we;
    w_c_addr  = (LATENCY == 1) ? req_addr  : r_addr;
    w_c_wdata = (LATENCY == 1) ? req_wdata : r_wdata;
    w_idx     = w_c_addr[ADDR_WIDTH-1:1];
    w_widx    = w_idx[AW-1:0];
    w_err     = w_c_addr[0] | ({2'b00, w_idx} >= DEPTH_L);
  end

  always_comb begin
    w_mem_we    = ~rst & w_commit & w_c_we & ~w_err;
    w_mem_waddr = w_widx;
    w_mem_wdata = w_c_wdata;
`ifdef DMEM_RESET_CLEAR_EN
    if (r_state == S_CLEAR) begin
      w_mem_we    = ~rst;
      w_mem_waddr = r_clr_cnt;
      w_mem_wdata = '0;
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (w_mem_we) r_mem[w_mem_waddr] <= w_mem_wdata;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
`ifdef DMEM_RESET_CLEAR_EN
      r_state   <= S_CLEAR;
      r_clr_cnt <= '0;
`else
      r_state   <= S_IDLE;
`endif
      r_cnt   <= 4'd0;
      r_we    <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_rdata <= '0;
      r_err   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE, S_RESP: begin
          if (w_accept) begin
            r_we    <= req_we;
            r_addr  <= req_addr;
            r_wdata <= req_wdata;
            if (LATENCY == 1) begin
              r_state <= S_RESP;
            end else begin
              r_state <= S_WAIT;
              r_cnt   <= 4'(LATENCY - 1);
            end
          end else begin
            r_state <= S_IDLE;
          end
        end
        // WAIT spans LATENCY cycles so a response lands in the cycle after edge N+LATENCY.
        S_WAIT: begin
          if (r_cnt == 4'd0) r_state <= S_RESP;
          else               r_cnt   <= r_cnt - 4'd1;
        end
`ifdef DMEM_RESET_CLEAR_EN
        S_CLEAR: begin
          r_clr_cnt <= r_clr_cnt + 1'b1;
          if (r_clr_cnt == AW'(DEPTH_WORDS - 1)) r_state <= S_IDLE;
        end
`endif
        default: r_state <= S_IDLE;
      endcase
      if (w_commit) begin
        r_err   <= w_err;
        r_rdata <= (!w_c_we && !w_err) ? r_mem[w_widx] : '0;
      end
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: a LATENCY=2 and a LATENCY=1 instance share the request bus;
// expected responses (data, error, arrival cycle) are queued at accept time and checked on rsp_valid.
module tb_dmem_responder;

  localparam int W = 49;  // {arrival cycle[31:0], err, rdata[15:0]}

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        v2 = 1'b0, v1 = 1'b0;
  logic        we = 1'b0;
  logic [15:0] addr = '0;
  logic [15:0] wdata = '0;
  logic        rdy2, rdy1, rv2, rv1, err2, err1, st2, st1;
  logic [15:0] rd2, rd1;
  logic [1:0]  dbg2, dbg1;

  int          n_checks = 0;
  int          n_fail = 0;
  int          cyc = 0;
  logic [W-1:0] exp_q2[$];
  logic [W-1:0] exp_q1[$];
  logic [15:0] model[2][256];

  dmem_responder #(.LATENCY(2)) dut (
    .clk(clk), .rst(rst), .req_valid(v2), .req_ready(rdy2), .req_we(we),
    .req_addr(addr), .req_wdata(wdata), .rsp_valid(rv2), .rsp_rdata(rd2),
    .rsp_err(err2), .stall(st2), .o_dbg_state(dbg2)
  );

  dmem_responder #(.LATENCY(1)) dut1 (
    .clk(clk), .rst(rst), .req_valid(v1), .req_ready(rdy1), .req_we(we),
    .req_addr(addr), .req_wdata(wdata), .rsp_valid(rv1), .rsp_rdata(rd1),
    .rsp_err(err1), .stall(st1), .o_dbg_state(dbg1)
  );

  // clock / cycle counter
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, required finish before 500000");
    $fatal(1, "watchdog");
  end

  // scoreboard monitors
  always @(negedge clk) begin
    logic [W-1:0] e;
    if (rv2 === 1'b1) begin
      n_checks++;
      if (exp_q2.size() == 0) begin
        n_fail++;
        $display("FAIL rsp_unexpected_lat2: got rdata=%h err=%b at cyc %0d, required no response", rd2, err2, cyc);
      end else begin
        e = exp_q2.pop_front();
        if ({err2, rd2} !== e[16:0] || cyc !== int'(e[48:17])) begin
          n_fail++;
          $display("FAIL rsp_lat2: got err=%b rdata=%h cyc=%0d, required err=%b rdata=%h cyc=%0d",
                   err2, rd2, cyc, e[16], e[15:0], e[48:17]);
        end
      end
    end
    if (rv1 === 1'b1) begin
      n_checks++;
      if (exp_q1.size() == 0) begin
        n_fail++;
        $display("FAIL rsp_unexpected_lat1: got rdata=%h err=%b at cyc %0d, required no response", rd1, err1, cyc);
      end else begin
        e = exp_q1.pop_front();
        if ({err1, rd1} !== e[16:0] || cyc !== int'(e[48:17])) begin
          n_fail++;
          $display("FAIL rsp_lat1: got err=%b rdata=%h cyc=%0d, required err=%b rdata=%h cyc=%0d",
                   err1, rd1, cyc, e[16], e[15:0], e[48:17]);
        end
      end
    end
  end

  // driver: present a request to one instance, queue its expectation when it is accepted
  task automatic send(input bit sel, input bit w, input logic [15:0] a, input logic [15:0] d,
                      output int waits, output int stalls);
    bit          done;
    bit          e_err;
    logic [15:0] e_dat;
    int          idx;
    we = w; addr = a; wdata = d;
    v1 = sel; v2 = !sel;
    waits = 0; stalls = 0; done = 0;
    for (int k = 0; k < 600 && !done; k++) begin
      @(negedge clk);
      if ((sel ? rdy1 : rdy2) === 1'b1) begin
        idx   = int'(a[15:1]);
        e_err = a[0] | (idx >= 256);
        e_dat = 16'h0000;
        if (!e_err && !w) e_dat = model[sel][idx];
        if (!e_err && w) model[sel][idx] = d;
        if (sel) exp_q1.push_back({32'(cyc + 1), e_err, e_dat});
        else     exp_q2.push_back({32'(cyc + 3), e_err, e_dat});
        done = 1;
      end else begin
        waits++;
        if ((sel ? st1 : st2) === 1'b1) stalls++;
      end
      @(posedge clk); #1;
    end
    if (!done) begin
      n_checks++; n_fail++;
      $display("FAIL send_timeout: addr=%h never accepted, required acceptance within 600 cycles", a);
    end
  endtask

  task automatic idle();
    v1 = 1'b0; v2 = 1'b0; we = 1'b0;
  endtask

  task automatic drain();
    bit done = 0;
    for (int k = 0; k < 50 && !done; k++) begin
      @(negedge clk);
      if (exp_q1.size() == 0 && exp_q2.size() == 0) done = 1;
    end
    n_checks++;
    if (!done) begin
      n_fail++;
      $display("FAIL drain: %0d/%0d responses outstanding, required 0/0", exp_q2.size(), exp_q1.size());
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    int zeros;
    idle();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    n_checks++;
    if ({rv2, rd2, err2, st2} !== 19'd0 || {rv1, rd1, err1, st1} !== 19'd0) begin
      n_fail++;
      $display("FAIL reset_outputs: got lat2 v=%b d=%h e=%b s=%b lat1 v=%b d=%h e=%b s=%b, required all 0",
               rv2, rd2, err2, st2, rv1, rd1, err1, st1);
    end
`ifdef DMEM_RESET_CLEAR_EN
    zeros = 0;
    for (int k = 0; k < 1000 && rdy2 !== 1'b1; k++) begin
      zeros++;
      @(negedge clk);
    end
    n_checks++;
    if (zeros != 256) begin
      n_fail++;
      $display("FAIL clear_ready_low: got %0d cycles with ready=0, required 256", zeros);
    end
    for (int i = 0; i < 256; i++) begin model[0][i] = 16'h0; model[1][i] = 16'h0; end
`else
    zeros = 0;
    n_checks++;
    if (rdy2 !== 1'b1 || rdy1 !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_ready: got %b/%b, required 1/1", rdy2, rdy1);
    end
`endif
    @(posedge clk); #1;
  endtask

  task automatic test_store_load();
    int w, s;
    send(0, 1'b1, 16'h0010, 16'hBEEF, w, s);
    idle(); drain();
    send(0, 1'b0, 16'h0010, 16'h0000, w, s);
    idle(); drain();
    repeat (2) @(negedge clk);
    n_checks++;
    if (rv2 !== 1'b0 || rd2 !== 16'hBEEF || err2 !== 1'b0) begin
      n_fail++;
      $display("FAIL rsp_hold: got v=%b d=%h e=%b, required v=0 d=beef e=0", rv2, rd2, err2);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_errors();
    int w, s;
    send(0, 1'b1, 16'h0000, 16'h0F0F, w, s);
    send(0, 1'b0, 16'h0011, 16'h0000, w, s);
    send(0, 1'b1, 16'h0201, 16'hDEAD, w, s);
    send(0, 1'b1, 16'h0200, 16'hDEAD, w, s);
    send(0, 1'b0, 16'h0000, 16'h0000, w, s);
    idle(); drain();
  endtask

  task automatic test_back_to_back();
    int w, s;
    send(0, 1'b0, 16'h0010, 16'h0000, w, s);
    for (int i = 0; i < 2; i++) begin
      send(0, 1'b0, (i == 0) ? 16'h0000 : 16'h0010, 16'h0000, w, s);
      n_checks++;
      if (w != 2 || s != 2) begin
        n_fail++;
        $display("FAIL b2b_ready_stall[%0d]: got ready-low=%0d stall=%0d, required 2 and 2", i, w, s);
      end
    end
    idle(); drain();
  endtask

  task automatic test_lat1();
    int w, s;
    send(1, 1'b1, 16'h0004, 16'h1234, w, s);
    send(1, 1'b0, 16'h0004, 16'h0000, w, s);
    n_checks++;
    if (w != 0) begin
      n_fail++;
      $display("FAIL lat1_b2b_ready: got %0d cycles with ready=0, required 0", w);
    end
    send(1, 1'b0, 16'h0005, 16'h0000, w, s);
    idle(); drain();
  endtask

  task automatic test_reset_drop();
    int w, s;
    logic [15:0] saved;
    send(0, 1'b1, 16'h0008, 16'h5555, w, s);
    idle(); drain();
    saved = model[0][4];
    send(0, 1'b1, 16'h0008, 16'hAAAA, w, s);
    idle();
    rst = 1'b1;
    void'(exp_q2.pop_back());
    model[0][4] = saved;
    @(posedge clk); #1 rst = 1'b0;
`ifdef DMEM_RESET_CLEAR_EN
    for (int i = 0; i < 256; i++) begin model[0][i] = 16'h0; model[1][i] = 16'h0; end
`endif
    repeat (4) @(posedge clk); #1;
    send(0, 1'b0, 16'h0008, 16'h0000, w, s);
    idle(); drain();
  endtask

  task automatic test_random();
    int w, s;
    for (int i = 0; i < 6; i++) begin
      send(i % 2, 1'b1, 16'((64 + i) * 2), 16'($urandom_range(0, 65535)), w, s);
      send((i + 1) % 2, 1'b1, 16'((64 + i) * 2), 16'($urandom_range(0, 65535)), w, s);
    end
    for (int i = 0; i < 10; i++) begin
      send($urandom_range(0, 1), 1'b0, 16'($urandom_range(64, 69) * 2), 16'h0000, w, s);
    end
    idle(); drain();
  endtask

  initial begin
    test_reset();
    test_store_load();
    test_errors();
    test_back_to_back();
    test_lat1();
    test_reset_drop();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
